buf_idx_alloc: RTL

- Clocked, parametrised successor to the router's combinational FIFO index map.
- Keeps a circular free list of shared-buffer slot indices and hands them out to NUM_CH input channels on request.
- Takes slot indices back on release, with a per-channel occupancy quota and double-free detection.
- Sits between the router's input-channel controllers and the shared packet buffer memory.

---
 rtl/buf_idx_alloc.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/buf_idx_alloc.sv
// Shared-buffer slot allocator: a circular free list of slot indices handed out to
// input channels, with per-channel quotas and double-free rejection on release.
module buf_idx_alloc #(
    parameter int DEPTH  = 3,
    parameter int PTR_SZ = 2,
    parameter int NUM_CH = 2,
    parameter int CH_SZ  = 1,
    parameter int QUOTA  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_req,
    input  logic [CH_SZ-1:0]             alloc_ch,
    output logic                         alloc_gnt,
    output logic [PTR_SZ-1:0]            alloc_idx,
    input  logic                         free_req,
    input  logic [CH_SZ-1:0]             free_ch,
    input  logic [PTR_SZ-1:0]            free_idx,
    output logic                         free_err,
    output logic [PTR_SZ:0]              free_cnt,
    output logic [NUM_CH*(PTR_SZ+1)-1:0] ch_cnt,
    output logic                         init_done
);

    localparam int SLOTS = 1 << PTR_SZ;
    localparam logic [PTR_SZ:0] DEPTH_CNT = (PTR_SZ+1)'(DEPTH);

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t              state_reg, state_next;
    logic [PTR_SZ-1:0]   k_reg, k_next;
    logic [PTR_SZ-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_SZ-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_SZ:0]     free_cnt_reg, free_cnt_next;
    logic [PTR_SZ:0]     ch_cnt_reg  [NUM_CH];
    logic [PTR_SZ:0]     ch_cnt_next [NUM_CH];
    logic [SLOTS-1:0]    in_use_reg, in_use_next;
    logic                gnt_reg, gnt_next;
    logic [PTR_SZ-1:0]   idx_reg, idx_next;
    logic                err_reg, err_next;
    logic                done_reg, done_next;

    logic [PTR_SZ-1:0]   list_mem [DEPTH];
    logic                list_we;
    logic [PTR_SZ-1:0]   list_waddr, list_wdata;
    logic [PTR_SZ-1:0]   head;
    logic                alloc_ok, free_ok;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_SZ-1:0] ptr_inc(input logic [PTR_SZ-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign head = list_mem[rd_ptr_reg];

    // Both decisions look only at pre-edge state, so a same-cycle release never
    // bypasses an empty list or a full quota.
    assign alloc_ok = alloc_req && (free_cnt_reg != '0) && (int'(alloc_ch) < NUM_CH)
                      && (int'(ch_cnt_reg[alloc_ch]) < QUOTA);
    assign free_ok  = free_req && (int'(free_ch) < NUM_CH) && (int'(free_idx) < DEPTH)
                      && in_use_reg[free_idx] && (ch_cnt_reg[free_ch] != '0);

    always_comb begin
        state_next    = state_reg;
        k_next        = k_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        free_cnt_next = free_cnt_reg;
        in_use_next   = in_use_reg;
        for (int i = 0; i < NUM_CH; i++) ch_cnt_next[i] = ch_cnt_reg[i];
        gnt_next      = 1'b0;
        idx_next      = idx_reg;
        err_next      = 1'b0;
        done_next     = done_reg;
        list_we       = 1'b0;
        list_waddr    = k_reg;
        list_wdata    = k_reg;
        case (state_reg)
            S_INIT: begin
                list_we  = 1'b1;
                err_next = free_req;
                if (int'(k_reg) == DEPTH - 1) begin
                    state_next    = S_READY;
                    free_cnt_next = DEPTH_CNT;
                    wr_ptr_next   = '0;
                    done_next     = 1'b1;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            S_READY: begin
                gnt_next = alloc_ok;
                err_next = free_req && !free_ok;
                if (alloc_ok) begin
                    idx_next              = head;
                    rd_ptr_next           = ptr_inc(rd_ptr_reg);
                    in_use_next[head]     = 1'b1;
                    ch_cnt_next[alloc_ch] = ch_cnt_next[alloc_ch] + 1'b1;
                end
                if (free_ok) begin
                    list_we               = 1'b1;
                    list_waddr            = wr_ptr_reg;
                    list_wdata            = free_idx;
                    wr_ptr_next           = ptr_inc(wr_ptr_reg);
                    in_use_next[free_idx] = 1'b0;
                    ch_cnt_next[free_ch]  = ch_cnt_next[free_ch] - 1'b1;
                end
                if (alloc_ok && !free_ok)
                    free_cnt_next = free_cnt_reg - 1'b1;
                else if (free_ok && !alloc_ok)
                    free_cnt_next = free_cnt_reg + 1'b1;
            end
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_INIT;
            k_reg        <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            free_cnt_reg <= '0;
            in_use_reg   <= '0;
            for (int i = 0; i < NUM_CH; i++) ch_cnt_reg[i] <= '0;
            gnt_reg      <= 1'b0;
            idx_reg      <= '0;
            err_reg      <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            k_reg        <= k_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            free_cnt_reg <= free_cnt_next;
            in_use_reg   <= in_use_next;
            for (int i = 0; i < NUM_CH; i++) ch_cnt_reg[i] <= ch_cnt_next[i];
            gnt_reg      <= gnt_next;
            idx_reg      <= idx_next;
            err_reg      <= err_next;
            done_reg     <= done_next;
        end
    end

    // Free-list storage carries no reset; INIT rewrites every entry.
    always_ff @(posedge clk) begin
        if (list_we) list_mem[list_waddr] <= list_wdata;
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_cnt
            assign ch_cnt[gi*(PTR_SZ+1) +: PTR_SZ+1] = ch_cnt_reg[gi];
        end
    endgenerate

    assign alloc_gnt = gnt_reg;
    assign alloc_idx = idx_reg;
    assign free_err  = err_reg;
    assign free_cnt  = free_cnt_reg;
    assign init_done = done_reg;

endmodule
